// File: rtl/sctr_pipe_pkg.sv
// rtl/sctr_pipe_pkg.sv - shared FSM encodings and defaults for the sctr_pipe memory-stage sequencer
package sctr_pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DIV  = 2'd3
  } state_t;

  localparam int SCTR_TO_CYC_DEF = 255;

endpackage

// File: rtl/sctr_tmo.sv
// rtl/sctr_tmo.sv - bus wait counter; hit once LIMIT cycles have elapsed since the last clear
module sctr_tmo #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + W'(1);
    end
  end

  assign hit = (cnt == W'(LIMIT));

endmodule

// File: rtl/sctr_pipe.sv
// rtl/sctr_pipe.sv - memory-stage sequencer: pipeline accesses onto a valid/ready cmd/rsp bus, divider stall
// Optional bus timeout is compiled in with SCTR_TIMEOUT_EN.
module sctr_pipe
  import sctr_pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter bit WR_RSP = 1'b0,
  parameter int TO_CYC = SCTR_TO_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            reg_we_i,
  input  logic            csr_we_i,
  input  logic            mem_en_i,
  input  logic            mem_we_i,
  input  logic [AW-1:0]   mem_addr_i,
  input  logic [DW-1:0]   mem_wdata_i,
  input  logic [DW/8-1:0] mem_wem_i,
  output logic [DW-1:0]   mem_rdata_o,
  input  logic            div_start_i,
  input  logic            div_ready_i,
  input  logic            iram_rstn_i,
  output logic            reg_we_o,
  output logic            csr_we_o,
  output logic            iram_rd_o,
  output logic            hx_valid,
  output logic [DW-1:0]   sctr_cmd_wdata,
  output logic [AW-1:0]   sctr_cmd_addr,
  output logic            sctr_cmd_we,
  output logic [DW/8-1:0] sctr_cmd_wem,
  output logic            sctr_cmd_valid,
  input  logic            sctr_cmd_ready,
  input  logic [DW-1:0]   sctr_rsp_rdata,
  input  logic            sctr_rsp_valid,
  input  logic            sctr_rsp_error,
  output logic            sctr_rsp_ready,
  output logic            bus_err_o,
  output logic [AW-1:0]   bus_err_addr_o
);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, err_addr_q;
  logic [DW-1:0]   wdata_q;
  logic            we_q;
  logic [DW/8-1:0] wem_q;
  logic            latch, retire, err, rd_ret, cmd_v, rsp_rdy, tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wem_q      <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        we_q    <= mem_we_i;
        wem_q   <= mem_wem_i;
      end
      if (err) err_addr_q <= addr_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    latch          = 1'b0;
    retire         = 1'b0;
    err            = 1'b0;
    rd_ret         = 1'b0;
    cmd_v          = 1'b0;
    rsp_rdy        = 1'b0;
    sctr_cmd_addr  = addr_q;
    sctr_cmd_wdata = wdata_q;
    sctr_cmd_we    = we_q;
    sctr_cmd_wem   = wem_q;
    case (state_q)
      ST_IDLE: begin
        if (!iram_rstn_i) begin
          if (div_start_i) begin
            state_d = ST_DIV;
          end else if (mem_en_i) begin
            // Issue straight from the pipeline inputs; the copy covers stalls and error reporting.
            cmd_v          = 1'b1;
            latch          = 1'b1;
            sctr_cmd_addr  = mem_addr_i;
            sctr_cmd_wdata = mem_wdata_i;
            sctr_cmd_we    = mem_we_i;
            sctr_cmd_wem   = mem_wem_i;
            if (!sctr_cmd_ready)        state_d = ST_CMD;
            else if (mem_we_i && !WR_RSP) retire  = 1'b1;
            else                        state_d = ST_RSP;
          end else begin
            retire = 1'b1;
          end
        end
      end
      ST_CMD: begin
        if (tmo_hit) begin
          retire  = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cmd_v = 1'b1;
          if (sctr_cmd_ready) begin
            if (we_q && !WR_RSP) begin
              retire  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RSP;
            end
          end
        end
      end
      ST_RSP: begin
        rsp_rdy = 1'b1;
        if (sctr_rsp_valid) begin
          retire  = 1'b1;
          err     = sctr_rsp_error;
          rd_ret  = !sctr_rsp_error && !we_q;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          retire  = 1'b1;
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (div_ready_i) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gating with rst_n drops every strobe the instant reset asserts, mid-transaction included.
  assign hx_valid       = rst_n & retire;
  assign iram_rd_o      = hx_valid;
  assign reg_we_o       = reg_we_i & hx_valid & ~err;
  assign csr_we_o       = csr_we_i & hx_valid & ~err;
  assign mem_rdata_o    = (hx_valid && rd_ret) ? sctr_rsp_rdata : '0;
  assign sctr_cmd_valid = rst_n & cmd_v;
  assign sctr_rsp_ready = rst_n & rsp_rdy;
  assign bus_err_o      = rst_n & err;
  assign bus_err_addr_o = err ? addr_q : err_addr_q;

`ifdef SCTR_TIMEOUT_EN
  logic tmo_clr, tmo_en;

  assign tmo_clr = (state_q != state_d);
  assign tmo_en  = (state_q == ST_CMD) || (state_q == ST_RSP);

  sctr_tmo #(
    .LIMIT(TO_CYC)
  ) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .hit  (tmo_hit)
  );
`else
  logic unused_to;
  assign unused_to = |TO_CYC;
  assign tmo_hit   = 1'b0;
`endif

endmodule
